// File: rtl/cache_controller_pkg.sv
// cache_pkg: shared cache geometry and controller state encoding.
package cache_pkg;
    localparam int ADDR_W   = 15;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 9;
    localparam int TAG_W    = 4;
    typedef enum logic [2:0] {IDLE, COMPARE, MISS_WAIT, FILL, DONE} state_t;
endpackage

// File: rtl/cache_controller_mem_latency_timer.sv
// mem_latency_timer: loadable down-counter that holds at zero and flags it.
module mem_latency_timer
    import cache_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/cache_controller.sv
// cache_controller: read-miss sequencing FSM for a direct-mapped cache.
// Optional STATS_EN adds saturating hit/miss counters; otherwise they read 0.
module cache_controller
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead,
    input  logic             hit,
    output logic             mem_read,
    output logic             cache_write,
    output logic             DataReady,
    output logic             HMbar,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int TW = $clog2(MEM_LATENCY) + 1;
    state_t state;
    logic   t_zero;
    mem_latency_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (state == COMPARE && !hit),
        .en      (state == MISS_WAIT),
        .load_val(TW'(MEM_LATENCY - 1)),
        .zero    (t_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            cache_write <= 1'b0;
            DataReady   <= 1'b0;
            HMbar       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (MemRead) state <= COMPARE;
                COMPARE: begin
                    state     <= hit ? DONE : MISS_WAIT;
                    HMbar     <= hit;
                    DataReady <= hit;
                    mem_read  <= !hit;
                end
                MISS_WAIT: if (t_zero) begin
                    state       <= FILL;
                    mem_read    <= 1'b0;
                    cache_write <= 1'b1;
                end
                // an abandoned request still completes its fill but never signals ready
                FILL: begin
                    cache_write <= 1'b0;
                    state       <= MemRead ? DONE : IDLE;
                    DataReady   <= MemRead;
                end
                DONE: if (!MemRead) begin
                    state     <= IDLE;
                    DataReady <= 1'b0;
                    HMbar     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE) begin
            if (hit && !(&hit_count)) hit_count <= hit_count + CNT_W'(1);
            if (!hit && !(&miss_count)) miss_count <= miss_count + CNT_W'(1);
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: random and directed checks of two controller instances
// (latency 4 / 32-bit stats, latency 1 / 2-bit stats) against a cycle-timeline model.
module tb_cache_controller;
    import cache_pkg::*;
`ifdef STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr0 = 1'b0, hv0 = 1'b0, mr1 = 1'b0, hv1 = 1'b0;
    logic        m0, w0, d0, h0, m1, w1, d1, h1;
    logic [31:0] hc0, mc0;
    logic [1:0]  hc1, mc1;
    int          checks = 0, failures = 0;
    int          exp_h[2], exp_m[2];
    logic        clr = 1'b0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [(1<<INDEX_W)-1:0] vld;
    logic [TAG_W-1:0] tgm[1<<INDEX_W];

    always #5 clk = ~clk;

    cache_controller #(.MEM_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .MemRead(mr0), .hit(hv0), .mem_read(m0), .cache_write(w0),
        .DataReady(d0), .HMbar(h0), .hit_count(hc0), .miss_count(mc0));
    cache_controller #(.MEM_LATENCY(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .MemRead(mr1), .hit(hv1), .mem_read(m1), .cache_write(w1),
        .DataReady(d1), .HMbar(h1), .hit_count(hc1), .miss_count(mc1));

    // behavioural cache datapath for the latency-4 instance
    always @(posedge clk) begin
        if (clr) vld <= '0;
        else if (w0) begin
            vld[cur_addr[OFFSET_W +: INDEX_W]] <= 1'b1;
            tgm[cur_addr[OFFSET_W +: INDEX_W]] <= cur_addr[ADDR_W-1 -: TAG_W];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] outs(input int u);
        return u != 0 ? {m1, w1, d1, h1} : {m0, w0, d0, h0};
    endfunction

    task automatic chk_stats(input int u, input string tag);
        chk({tag, " hit_count"}, u != 0 ? 32'(hc1) : hc0, STATS ? 32'(exp_h[u]) : 32'd0);
        chk({tag, " miss_count"}, u != 0 ? 32'(mc1) : mc0, STATS ? 32'(exp_m[u]) : 32'd0);
    endtask

    // one request: MemRead high in cycles 0..d-1, hit presented in the COMPARE cycle (1)
    task automatic txn(input int u, input bit h, input int d);
        int l, n, last;
        bit mr, cw, dr;
        l = u != 0 ? 1 : 4;
        last = h ? (d > 2 ? d : 2) : (d > l + 2 ? d : l + 2);
        n = last + 1;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            mr = !h && c >= 2 && c <= l + 1;
            cw = !h && c == l + 2;
            dr = h ? (c >= 2 && c <= last) : (d > l + 2 && c >= l + 3 && c <= d);
            chk($sformatf("u%0d h%0d d%0d cyc%0d outs", u, h, d, c), 32'(outs(u)),
                32'({mr, cw, dr, h && dr}));
            if (c == 0) begin
                if (h && !(u == 1 && exp_h[1] == 3)) exp_h[u]++;
                if (!h && !(u == 1 && exp_m[1] == 3)) exp_m[u]++;
            end
            if (u != 0) begin
                mr1 = c < d;
                hv1 = c == 1 ? h : 1'($urandom);
            end else begin
                mr0 = c < d;
                hv0 = c == 1 ? h : 1'($urandom);
            end
        end
        chk_stats(u, $sformatf("u%0d after txn", u));
    endtask

    initial begin
        int h_before, m_before, l;
        bit h;
        exp_h = '{0, 0};
        exp_m = '{0, 0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset outs u0", 32'(outs(0)), 32'd0);
        chk("reset outs u1", 32'(outs(1)), 32'd0);
        chk_stats(0, "reset");
        chk_stats(1, "reset");
        // directed latency-4 cases
        txn(0, 1'b1, 4);
        txn(0, 1'b0, 9);
        txn(0, 1'b0, 3);
        txn(0, 1'b1, 1);
        txn(0, 1'b0, 1);
        // directed latency-1 cases
        txn(1, 1'b0, 6);
        txn(1, 1'b0, 2);
        txn(1, 1'b1, 2);
        // reset in the middle of a miss
        @(negedge clk); mr0 = 1'b1; hv0 = 1'b0;
        @(negedge clk); hv0 = 1'b0;
        @(negedge clk); chk("pre-reset mem_read", 32'(outs(0)), 32'b1000); rst = 1'b1;
        @(negedge clk); chk("in-reset outs", 32'(outs(0)), 32'd0); mr0 = 1'b0;
        @(negedge clk); rst = 1'b0;
        exp_h = '{0, 0};
        exp_m = '{0, 0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset outs cyc%0d", i), 32'(outs(0)), 32'd0);
        end
        chk_stats(0, "post-reset");
        chk_stats(1, "post-reset");
        txn(0, 1'b1, 3);
        // saturation of the 2-bit counters
        for (int i = 0; i < 5; i++) txn(1, 1'b1, 2);
        for (int i = 0; i < 5; i++) txn(1, 1'b0, 5);
        // random requests on both instances
        for (int i = 0; i < 300; i++) begin
            int u;
            u = int'($urandom_range(0, 1));
            l = u != 0 ? 1 : 4;
            h = 1'($urandom);
            txn(u, h, int'($urandom_range(1, h ? 5 : l + 5)));
        end
        // sequential address sweep through the behavioural datapath
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        h_before = int'(hc0);
        m_before = int'(mc0);
        for (int a = 1024; a < 1024 + 4096; a++) begin
            cur_addr = ADDR_W'(a);
            h = vld[cur_addr[OFFSET_W +: INDEX_W]] &&
                tgm[cur_addr[OFFSET_W +: INDEX_W]] == cur_addr[ADDR_W-1 -: TAG_W];
            txn(0, h, int'($urandom_range(1, h ? 4 : 7)));
        end
        chk("sweep hits", hc0 - 32'(h_before), STATS ? 32'd3072 : 32'd0);
        chk("sweep misses", mc0 - 32'(m_before), STATS ? 32'd1024 : 32'd0);
        $display("sweep hits=%0d misses=%0d", hc0 - 32'(h_before), mc0 - 32'(m_before));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for the direct-mapped cache inside the memory hierarchy (15-bit word address, 32-bit words, 4-word blocks).
- Takes the requester's MemRead and the cache datapath's hit flag.
- Drives the main-memory block read (with modelled latency), the cache line fill, and the DataReady/HMbar handshake back to the requester.
- Sits between the requester interface and the cache/main-memory datapath.

Parameters:
- MEM_LATENCY, 4, cycles main memory holds mem_read before the block is valid; legal range >= 1.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- MemRead  in  1  read request level; requester holds it and keeps address stable until DataReady, then drops it.
- hit  in  1  combinational valid&&tag-match from the cache datapath for the current address.
- mem_read  out  1  main-memory block read enable.
- cache_write  out  1  one-cycle strobe; datapath writes the 4-word block, tag and valid bit.
- DataReady  out  1  requested word is valid on the datapath data bus.
- HMbar  out  1  1 = hit, 0 = miss; valid while DataReady = 1.
- hit_count  out  CNT_W  hits since reset (STATS_EN only).
- miss_count  out  CNT_W  misses since reset (STATS_EN only).

Behaviour:
- Reset: rst sampled high at a rising edge moves the FSM to IDLE and clears the latency counter and the stats. All outputs are 0 from the next cycle. Reset overrides any state, including mid-miss; no cache_write is issued after reset.
- All outputs are registered Moore outputs of the state, with HMbar held in a flag register.
- IDLE: outputs 0. MemRead = 1 goes to COMPARE; otherwise stay.
- COMPARE: hit is sampled at the edge leaving this state.
  - hit = 1: go to DONE, set HMbar = 1, increment hit_count.
  - hit = 0: go to MISS_WAIT, load latency counter = MEM_LATENCY-1, set HMbar = 0, increment miss_count.
- MISS_WAIT: mem_read = 1. The counter decrements each cycle; at 0 go to FILL. With MEM_LATENCY = 1 this state lasts exactly one cycle.
- FILL: cache_write = 1 for exactly one cycle.
  - MemRead = 1: go to DONE.
  - MemRead = 0 (request abandoned): go to IDLE. The fill still completes, so the cache stays consistent, and DataReady is never asserted.
- DONE: DataReady = 1. Stay while MemRead = 1; MemRead = 0 goes to IDLE, and DataReady drops the following cycle.
- Latency, with MemRead sampled high in IDLE at edge 0:
  - hit: DataReady high from cycle 2;
  - miss: mem_read high cycles 2..MEM_LATENCY+1, cache_write at cycle MEM_LATENCY+2, DataReady from cycle MEM_LATENCY+3.
- MemRead dropped during COMPARE: the decision and counting still happen.
  - hit path: DONE lasts one cycle (DataReady pulses once).
  - miss path: the abandon rule applies.
- hit is ignored in every state other than COMPARE.
- Stats counters saturate at all-ones; no wrap.
- Back-to-back requests: new MemRead is accepted only in IDLE, so there is a minimum of one idle cycle between requests.

Optional Feature:
- STATS_EN: defined -> hit_count/miss_count are implemented as above.
- Undefined -> no counter registers; both outputs are tied to 0. All other behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - ADDR_W = 15, WORD_W = 32, OFFSET_W = 2, INDEX_W = 9, TAG_W = 4;
  - the state enum {IDLE, COMPARE, MISS_WAIT, FILL, DONE}.
- One sub-module: mem_latency_timer, a loadable down-counter with a load/enable input and a zero flag, width clog2(MEM_LATENCY)+1. Instantiated once for MISS_WAIT.

Test Plan:
- Reset: rst high 2 cycles during a miss -> all outputs 0, state IDLE, counters 0, no cache_write afterwards.
- Hit (MEM_LATENCY = 4): hit = 1, MemRead raised at edge 0 -> DataReady = 1 and HMbar = 1 at cycle 2, mem_read never 1, hit_count = 1. MemRead dropped at cycle 4 -> DataReady = 0 at cycle 5.
- Miss (MEM_LATENCY = 4): hit = 0 -> mem_read = 1 cycles 2..5, cache_write = 1 at cycle 6 only, DataReady = 1 with HMbar = 0 at cycle 7, miss_count = 1.
- Abandon: miss with MemRead dropped at cycle 3 -> cache_write still pulses at cycle 6, DataReady stays 0, IDLE at cycle 7.
- MEM_LATENCY = 1 miss -> mem_read exactly one cycle (cycle 2), cache_write at cycle 3, DataReady at cycle 4.
- Sweep: 4096 sequential addresses from 1024 with a behavioural cache datapath -> 1024 misses, 3072 hits, hit rate 75%. Stats match with STATS_EN; counters read 0 without it.
